lcd_reader: RTL and testbench

LCD_READER -- requirements
Module: lcd_reader

---
 rtl/lcd_reader.sv | 115 +++++++++++
 tb/tb_lcd_reader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_reader.sv
// HD44780 4-bit read sequencer: one 8-bit read as two E strobes,
// high nibble first, with programmable setup/pulse/gap timing.
module lcd_reader #(
   parameter int T_AS  = 4,
   parameter int T_PW  = 25,
   parameter int T_GAP = 30
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start,
   input  logic       rs,
   input  logic [3:0] LCD_D_IN,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_E,
   output logic [7:0] data_out,
   output logic       busy_flag,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE, SETUP, E_HI1, E_LO1, E_HI2, E_LO2, DONE
   } state_t;

   localparam logic [7:0] AS_L  = 8'(T_AS - 1);
   localparam logic [7:0] PW_L  = 8'(T_PW - 1);
   localparam logic [7:0] GAP_L = 8'(T_GAP - 1);

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic       rs_q;
   logic [7:0] shadow;

   // Each timed state is loaded with its length minus one and leaves at zero
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (state != IDLE && cnt != 8'd0) begin
         cnt_nx = cnt - 8'd1;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state_nx = SETUP;
                  cnt_nx   = AS_L;
               end
            end
            SETUP: begin
               state_nx = E_HI1;
               cnt_nx   = PW_L;
            end
            E_HI1: begin
               state_nx = E_LO1;
               cnt_nx   = GAP_L;
            end
            E_LO1: begin
               state_nx = E_HI2;
               cnt_nx   = PW_L;
            end
            E_HI2: begin
               state_nx = E_LO2;
               cnt_nx   = GAP_L;
            end
            E_LO2: begin
               state_nx = DONE;
               cnt_nx   = 8'd0;
            end
            DONE: begin
               state_nx = IDLE;
               cnt_nx   = 8'd0;
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = 8'd0;
            end
         endcase
      end
   end

   assign busy   = (state != IDLE);
   assign LCD_RW = busy;
   assign LCD_RS = busy & rs_q;
   assign LCD_E  = (state == E_HI1) || (state == E_HI2);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         rs_q      <= 1'b0;
         shadow    <= 8'h00;
         data_out  <= 8'h00;
         busy_flag <= 1'b0;
         done      <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         done  <= 1'b0;
         if (state == IDLE && start)
            rs_q <= rs;
         // Nibble is taken on the last clock of E high, just before the fall
         if (state == E_HI1 && cnt == 8'd0)
            shadow[7:4] <= LCD_D_IN;
         if (state == E_HI2 && cnt == 8'd0)
            shadow[3:0] <= LCD_D_IN;
         if (state == DONE) begin
            data_out <= shadow;
            done     <= 1'b1;
            if (!rs_q)
               busy_flag <= shadow[7];
         end
      end
   end

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: default timing instance plus a
// minimum-timing instance sharing the same stimulus.
module tb_lcd_reader;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       start = 1'b0;
   logic       rs = 1'b0;
   logic [3:0] d_in = 4'h0;
   logic       sel = 1'b0;

   logic       rs1, rw1, e1, bf1, b1, dn1;
   logic [7:0] do1;
   logic       rs2, rw2, e2, bf2, b2, dn2;
   logic [7:0] do2;

   logic       rs_o, rw, e, bf, bsy, dn;
   logic [7:0] dout;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   lcd_reader u_dut (
      .CLK(CLK), .RST(RST), .start(start), .rs(rs), .LCD_D_IN(d_in),
      .LCD_RS(rs1), .LCD_RW(rw1), .LCD_E(e1), .data_out(do1),
      .busy_flag(bf1), .busy(b1), .done(dn1)
   );

   lcd_reader #(.T_AS(1), .T_PW(1), .T_GAP(1)) u_fast (
      .CLK(CLK), .RST(RST), .start(start), .rs(rs), .LCD_D_IN(d_in),
      .LCD_RS(rs2), .LCD_RW(rw2), .LCD_E(e2), .data_out(do2),
      .busy_flag(bf2), .busy(b2), .done(dn2)
   );

   assign rs_o = sel ? rs2 : rs1;
   assign rw   = sel ? rw2 : rw1;
   assign e    = sel ? e2  : e1;
   assign bf   = sel ? bf2 : bf1;
   assign bsy  = sel ? b2  : b1;
   assign dn   = sel ? dn2 : dn1;
   assign dout = sel ? do2 : do1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller sits at a negedge; the next posedge samples start.
   // lat = edges from the sampling edge to the clock where done is seen.
   task automatic run(input logic rsv, input logic [3:0] hi,
                      input logic [3:0] lo, input int pulse_at,
                      input bit hold, output int lat, output int hiclk,
                      output int rises, output int bad);
      logic pe;
      lat = -1;
      hiclk = 0;
      rises = 0;
      bad = 0;
      pe = 1'b0;
      start = 1'b1;
      rs = rsv;
      @(posedge CLK);
      for (int n = 0; n < 400; n++) begin
         @(negedge CLK);
         if (!hold) begin
            start = (n == pulse_at);
            rs = ~rsv;
         end
         if (e && !pe) rises++;
         pe = e;
         if (e) hiclk++;
         d_in = e ? ((rises == 1) ? hi : lo) : 4'hF;
         if (dn) begin
            lat = n;
            break;
         end
         if (!(rw === 1'b1 && rs_o === rsv && bsy === 1'b1)) bad++;
         @(posedge CLK);
      end
   endtask

   initial begin
      int lat, hc, rz, bad, ndone;

      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_e", e, 0);
      chk("rst_rw", rw, 0);
      chk("rst_rs", rs_o, 0);
      chk("rst_busy", bsy, 0);
      chk("rst_done", dn, 0);
      chk("rst_data", dout, 8'h00);
      chk("rst_bf", bf, 0);
      RST = 1'b0;
      @(negedge CLK);

      run(1'b0, 4'h8, 4'h3, -1, 1'b0, lat, hc, rz, bad);
      chk("r83_lat", lat, 115);
      chk("r83_data", dout, 8'h83);
      chk("r83_bf", bf, 1);
      chk("r83_ctl", bad, 0);
      chk("r83_idle_rw", rw, 0);

      run(1'b1, 4'hA, 4'h5, -1, 1'b0, lat, hc, rz, bad);
      chk("rA5_lat", lat, 115);
      chk("rA5_data", dout, 8'hA5);
      chk("rA5_bf_kept", bf, 1);
      chk("rA5_ctl", bad, 0);
      chk("rA5_ehigh", hc, 50);
      chk("rA5_rises", rz, 2);

      run(1'b0, 4'h0, 4'h3, -1, 1'b0, lat, hc, rz, bad);
      chk("r03_data", dout, 8'h03);
      chk("r03_bf", bf, 0);

      run(1'b1, 4'h6, 4'h9, 10, 1'b0, lat, hc, rz, bad);
      chk("ign_lat", lat, 115);
      chk("ign_data", dout, 8'h69);
      chk("ign_rises", rz, 2);
      chk("ign_ehigh", hc, 50);
      ndone = 0;
      for (int i = 0; i < 130; i++) begin
         @(negedge CLK);
         if (dn) ndone++;
      end
      chk("ign_no_2nd_done", ndone, 0);
      chk("ign_hold_data", dout, 8'h69);
      chk("ign_hold_bf", bf, 0);

      run(1'b1, 4'h3, 4'hC, -1, 1'b1, lat, hc, rz, bad);
      chk("b2b1_lat", lat, 115);
      chk("b2b1_data", dout, 8'h3C);
      chk("b2b_rw_idle", rw, 0);
      run(1'b1, 4'h3, 4'hC, -1, 1'b1, lat, hc, rz, bad);
      start = 1'b0;
      chk("b2b2_sep", lat + 1, 116);
      chk("b2b2_rw_hi", bad, 0);
      chk("b2b2_data", dout, 8'h3C);

      @(negedge CLK);
      start = 1'b1;
      rs = 1'b1;
      @(posedge CLK);
      for (int n = 0; n <= 65; n++) begin
         @(negedge CLK);
         start = 1'b0;
      end
      chk("mid_e_high", e, 1);
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      chk("abort_e", e, 0);
      chk("abort_rw", rw, 0);
      chk("abort_busy", bsy, 0);
      chk("abort_data", dout, 8'h00);
      ndone = 0;
      for (int i = 0; i < 150; i++) begin
         if (dn) ndone++;
         @(negedge CLK);
      end
      chk("abort_no_done", ndone, 0);

      sel = 1'b1;
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      run(1'b0, 4'h9, 4'hC, -1, 1'b0, lat, hc, rz, bad);
      chk("fast_lat", lat, 6);
      chk("fast_data", dout, 8'h9C);
      chk("fast_bf", bf, 1);
      chk("fast_ehigh", hc, 2);
      chk("fast_ctl", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
